// File: rtl/mod_exp_ctrl.sv
// Sequencer for left-to-right square-and-multiply modular exponentiation.
// Walks the exponent MSB-first and steers one shared Montgomery multiplier in the datapath.
module mod_exp_ctrl #(
  parameter int unsigned EXP_WIDTH = 1024,
  parameter int unsigned CNT_WIDTH = 11
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [EXP_WIDTH-1:0] exp,
  output logic                 busy,
  output logic                 done,
  output logic                 mm_start,
  input  logic                 mm_done,
  output logic [2:0]           mm_sel_a,
  output logic [2:0]           mm_sel_b,
  output logic                 mm_dst,
  output logic                 a_load_r,
  output logic [11:0]          mm_count
);

  localparam logic [2:0] SelA   = 3'd0;
  localparam logic [2:0] SelXt  = 3'd1;
  localparam logic [2:0] SelMsg = 3'd2;
  localparam logic [2:0] SelR2  = 3'd3;
  localparam logic [2:0] SelOne = 3'd4;
  localparam logic       DstA   = 1'b0;
  localparam logic       DstXt  = 1'b1;

  typedef enum logic [3:0] {
    StIdle, StInitXt, StWInit, StLoadA, StScan, StSquare,
    StWSq, StMult, StWMul, StFinal, StWFin, StDone
  } state_e;

  state_e                 state_q, state_d;
  logic [EXP_WIDTH-1:0]   shreg_q, shreg_d;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
  logic                   found_q, found_d;
  logic                   exp_bit_q, exp_bit_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   mm_start_q, mm_start_d;
  logic [2:0]             sel_a_q, sel_a_d;
  logic [2:0]             sel_b_q, sel_b_d;
  logic                   dst_q, dst_d;
  logic                   a_load_r_q, a_load_r_d;
  logic [11:0]            mm_count_q, mm_count_d;
  logic                   count_clr;
  logic [11:0]            count_base;

  // Outputs are set on entry to a state, so each pulse lines up with the state that owns it.
  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    cnt_d      = cnt_q;
    found_d    = found_q;
    exp_bit_d  = exp_bit_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    mm_start_d = 1'b0;
    a_load_r_d = 1'b0;
    sel_a_d    = sel_a_q;
    sel_b_d    = sel_b_q;
    dst_d      = dst_q;
    count_clr  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d    = StInitXt;
          shreg_d    = exp;
          cnt_d      = CNT_WIDTH'(EXP_WIDTH);
          found_d    = 1'b0;
          exp_bit_d  = 1'b0;
          busy_d     = 1'b1;
          count_clr  = 1'b1;
          mm_start_d = 1'b1;
          sel_a_d    = SelMsg;
          sel_b_d    = SelR2;
          dst_d      = DstXt;
        end
      end
      StInitXt: state_d = StWInit;
      StWInit: begin
        if (mm_done) begin
          state_d    = StLoadA;
          a_load_r_d = 1'b1;
        end
      end
      StLoadA: state_d = StScan;
      StScan: begin
        if (cnt_q == '0) begin
          state_d    = StFinal;
          mm_start_d = 1'b1;
          sel_a_d    = SelA;
          sel_b_d    = SelOne;
          dst_d      = DstA;
        end else begin
          shreg_d = {shreg_q[EXP_WIDTH-2:0], 1'b0};
          cnt_d   = cnt_q - CNT_WIDTH'(1);
          // Leading zeros are skipped one per cycle without touching the multiplier.
          if (found_q || shreg_q[EXP_WIDTH-1]) begin
            found_d    = 1'b1;
            exp_bit_d  = shreg_q[EXP_WIDTH-1];
            state_d    = StSquare;
            mm_start_d = 1'b1;
            sel_a_d    = SelA;
            sel_b_d    = SelA;
            dst_d      = DstA;
          end
        end
      end
      StSquare: state_d = StWSq;
      StWSq: begin
        if (mm_done) begin
          if (exp_bit_q) begin
            state_d    = StMult;
            mm_start_d = 1'b1;
            sel_a_d    = SelA;
            sel_b_d    = SelXt;
            dst_d      = DstA;
          end else begin
            state_d = StScan;
          end
        end
      end
      StMult: state_d = StWMul;
      StWMul: begin
        if (mm_done) state_d = StScan;
      end
      StFinal: state_d = StWFin;
      StWFin: begin
        if (mm_done) begin
          state_d = StDone;
          done_d  = 1'b1;
        end
      end
      StDone: begin
        state_d = StIdle;
        busy_d  = 1'b0;
      end
      default: state_d = StIdle;
    endcase

    count_base = count_clr ? 12'd0 : mm_count_q;
    mm_count_d = (mm_start_d && (count_base != 12'hfff)) ? count_base + 12'd1 : count_base;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      shreg_q    <= '0;
      cnt_q      <= '0;
      found_q    <= 1'b0;
      exp_bit_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      mm_start_q <= 1'b0;
      sel_a_q    <= 3'd0;
      sel_b_q    <= 3'd0;
      dst_q      <= 1'b0;
      a_load_r_q <= 1'b0;
      mm_count_q <= 12'd0;
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      cnt_q      <= cnt_d;
      found_q    <= found_d;
      exp_bit_q  <= exp_bit_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      mm_start_q <= mm_start_d;
      sel_a_q    <= sel_a_d;
      sel_b_q    <= sel_b_d;
      dst_q      <= dst_d;
      a_load_r_q <= a_load_r_d;
      mm_count_q <= mm_count_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign mm_start = mm_start_q;
  assign mm_sel_a = sel_a_q;
  assign mm_sel_b = sel_b_q;
  assign mm_dst   = dst_q;
  assign a_load_r = a_load_r_q;
  assign mm_count = mm_count_q;

endmodule

// File: tb/tb_mod_exp_ctrl.sv
// Bench for mod_exp_ctrl: fixed-latency Montgomery multiplier mock plus a small operand file,
// compared against an arithmetic reference (op list from exponent bits, msg^exp mod n).
module tb_mod_exp_ctrl;
  localparam int unsigned     EW = 1024;
  localparam longint unsigned N  = 64'd2147483647;
  localparam logic [6:0] OpInit = {3'd2, 3'd3, 1'b1};
  localparam logic [6:0] OpSq   = {3'd0, 3'd0, 1'b0};
  localparam logic [6:0] OpMul  = {3'd0, 3'd1, 1'b0};
  localparam logic [6:0] OpFin  = {3'd0, 3'd4, 1'b0};

  logic          clk = 1'b0;
  logic          reset, start, mm_done, busy, done, mm_start, mm_dst, a_load_r;
  logic [EW-1:0] exp_in;
  logic [2:0]    mm_sel_a, mm_sel_b;
  logic [11:0]   mm_count;
  logic          mock_done = 1'b0;
  logic          spur_done;
  logic          mon_clr;

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;
  int mul_lat = 1;
  int rem = 0;

  // Operand file of the datapath, Montgomery domain with R = 2^32.
  longint unsigned msg, r_val, r2_val, rinv, dp_a, dp_xt, pend_val, res_a;
  logic            pend_dst;
  logic [6:0]      cap_op;
  bit              inflight = 0;
  bit              prev_start = 0;

  logic [6:0] obs_q[$];
  int done_cnt, load_cnt, load_pos, drift, b2b, mdone_cnt, t_done;
  logic [11:0] cnt_at_done;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  assign mm_done = mock_done | spur_done;

  mod_exp_ctrl #(.EXP_WIDTH(EW), .CNT_WIDTH(11)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .exp      (exp_in),
    .busy     (busy),
    .done     (done),
    .mm_start (mm_start),
    .mm_done  (mm_done),
    .mm_sel_a (mm_sel_a),
    .mm_sel_b (mm_sel_b),
    .mm_dst   (mm_dst),
    .a_load_r (a_load_r),
    .mm_count (mm_count)
  );

  function automatic longint unsigned modpow(input longint unsigned b, input logic [EW-1:0] e);
    longint unsigned res = 1;
    longint unsigned sq = b % N;
    for (int i = 0; i < EW; i++) begin
      if (e[i]) res = (res * sq) % N;
      sq = (sq * sq) % N;
    end
    return res;
  endfunction

  function automatic longint unsigned mont(input longint unsigned a, input longint unsigned b);
    return (((a * b) % N) * rinv) % N;
  endfunction

  function automatic longint unsigned sel_val(input logic [2:0] s);
    case (s)
      3'd0:    return dp_a;
      3'd1:    return dp_xt;
      3'd2:    return msg;
      3'd3:    return r2_val;
      3'd4:    return 64'd1;
      default: return 64'd0;
    endcase
  endfunction

  // Monitor, multiplier mock and datapath, all sampled mid-cycle.
  always @(negedge clk) begin
    if (mon_clr) begin
      obs_q.delete();
      done_cnt = 0; load_cnt = 0; load_pos = -1; drift = 0; b2b = 0; mdone_cnt = 0;
    end
    if (mock_done) begin
      if (pend_dst) dp_xt = pend_val;
      else          dp_a  = pend_val;
      inflight = 0;
    end
    if (mm_done) mdone_cnt++;
    if (a_load_r) begin
      dp_a = r_val;
      load_cnt++;
      load_pos = obs_q.size();
    end
    if (inflight && ({mm_sel_a, mm_sel_b, mm_dst} != cap_op)) drift++;
    if (mm_start) begin
      if (prev_start) b2b++;
      obs_q.push_back({mm_sel_a, mm_sel_b, mm_dst});
      cap_op   = {mm_sel_a, mm_sel_b, mm_dst};
      pend_val = mont(sel_val(mm_sel_a), sel_val(mm_sel_b));
      pend_dst = mm_dst;
      inflight = 1;
    end
    prev_start = mm_start;
    if (done) begin
      done_cnt++;
      t_done      = cyc;
      res_a       = dp_a;
      cnt_at_done = mm_count;
    end
    mock_done = 1'b0;
    if (rem > 0) begin
      rem--;
      if (rem == 0) mock_done = 1'b1;
    end
    if (mm_start) rem = mul_lat;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic run_op(input string tag, input logic [EW-1:0] e, input int lat,
                        input bit disturb);
    logic [6:0] ref_q[$];
    int k = -1;
    int pop = 0;
    int n_mult, exp_lat, t0, nops;
    bit got = 0;
    for (int i = 0; i < EW; i++) if (e[i]) begin pop++; k = i; end
    ref_q.push_back(OpInit);
    for (int i = k; i >= 0; i--) begin
      ref_q.push_back(OpSq);
      if (e[i]) ref_q.push_back(OpMul);
    end
    ref_q.push_back(OpFin);
    n_mult  = 2 + (k + 1) + pop;
    exp_lat = 5 + (EW - 1 - k) + n_mult * (lat + 1) + (k + 1);
    msg     = 64'($urandom_range(2, 32'h7ffffff0));
    mul_lat = lat;

    @(posedge clk); #1;
    exp_in = e; start = 1'b1; mon_clr = 1'b1; t0 = cyc;
    @(posedge clk); #1;
    start = 1'b0; mon_clr = 1'b0;
    for (int w = 0; w < EW / 32; w++) exp_in[w*32 +: 32] = $urandom;
    check({tag, "_busy_after_start"}, 64'(busy), 64'd1);
    if (disturb) begin
      // Lands in the leading-zero SCAN stretch for the short exponents used here.
      repeat (lat + 8) @(posedge clk);
      #1; exp_in = '1; start = 1'b1; spur_done = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; spur_done = 1'b0;
    end
    for (int c = 0; c < exp_lat + 40 && !got; c++) begin
      @(posedge clk); #1;
      if (done_cnt > 0) got = 1;
    end
    check({tag, "_done_seen"}, 64'(got), 64'd1);
    repeat (4) @(posedge clk);
    #1;
    check({tag, "_done_once"}, 64'(done_cnt), 64'd1);
    check({tag, "_busy_idle"}, 64'(busy), 64'd0);
    check({tag, "_mm_count"}, 64'(cnt_at_done), 64'(n_mult));
    // Window runs from the start cycle through the first idle cycle after done, inclusive.
    check({tag, "_latency"}, 64'(t_done - t0 + 2), 64'(exp_lat));
    check({tag, "_n_ops"}, 64'(obs_q.size()), 64'(ref_q.size()));
    nops = (obs_q.size() < ref_q.size()) ? obs_q.size() : ref_q.size();
    for (int i = 0; i < nops; i++) check($sformatf("%s_op%0d", tag, i), 64'(obs_q[i]), 64'(ref_q[i]));
    check({tag, "_a_load_cnt"}, 64'(load_cnt), 64'd1);
    check({tag, "_a_load_pos"}, 64'(load_pos), 64'd1);
    check({tag, "_sel_stable"}, 64'(drift), 64'd0);
    check({tag, "_no_b2b"}, 64'(b2b), 64'd0);
    check({tag, "_result"}, res_a, modpow(msg, e));
  endtask

  initial begin
    logic [EW-1:0] e;
    logic [EW-1:0] ev;
    bit got;
    int w;
    reset = 1'b1; start = 1'b0; exp_in = '0; spur_done = 1'b0; mon_clr = 1'b0;
    r_val  = (64'd1 << 32) % N;
    r2_val = (r_val * r_val) % N;
    ev = '0; ev[63:0] = N - 2;
    rinv = modpow(r_val, ev);
    dp_a = 0; dp_xt = 0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_mm_start", 64'(mm_start), 64'd0);
    check("rst_a_load_r", 64'(a_load_r), 64'd0);
    check("rst_sels", 64'({mm_sel_a, mm_sel_b, mm_dst}), 64'd0);
    check("rst_mm_count", 64'(mm_count), 64'd0);
    reset = 1'b0;

    e = '0; e[15:0] = 16'hce7b;
    run_op("ce7b", e, 20, 1'b0);
    e = '0; e[0] = 1'b1;
    run_op("one", e, 3, 1'b0);
    run_op("zero", '0, 4, 1'b0);
    e = '0; e[15:0] = 16'hce7b;
    run_op("ce7b_dist", e, 20, 1'b1);

    // Reset while waiting on a square; the pending multiplier result lands after reset.
    mul_lat = 20;
    @(posedge clk); #1;
    exp_in = e; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    got = 0;
    for (int c = 0; c < 1200 && !got; c++) begin
      @(posedge clk); #1;
      if (mm_start && mm_sel_a == 3'd0 && mm_sel_b == 3'd0) got = 1;
    end
    check("rst_mid_square_seen", 64'(got), 64'd1);
    @(posedge clk); #1;
    reset = 1'b1; mon_clr = 1'b1;
    @(posedge clk); #1;
    mon_clr = 1'b0;
    check("rst_mid_busy", 64'(busy), 64'd0);
    check("rst_mid_mm_start", 64'(mm_start), 64'd0);
    check("rst_mid_sels", 64'({mm_sel_a, mm_sel_b, mm_dst}), 64'd0);
    check("rst_mid_mm_count", 64'(mm_count), 64'd0);
    repeat (2) @(posedge clk);
    #1; reset = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    check("rst_late_done_given", 64'(mdone_cnt), 64'd1);
    check("rst_late_no_start", 64'(obs_q.size()), 64'd0);
    check("rst_late_no_done", 64'(done_cnt), 64'd0);
    check("rst_late_busy", 64'(busy), 64'd0);
    check("rst_late_count", 64'(mm_count), 64'd0);

    for (int r = 0; r < 6; r++) begin
      w = $urandom_range(1, 48);
      e = '0;
      e[31:0]  = $urandom;
      e[47:32] = 16'($urandom);
      for (int i = 0; i < EW; i++) if (i >= w) e[i] = 1'b0;
      e[w-1] = 1'b1;
      run_op($sformatf("rand%0d", r), e, $urandom_range(1, 6), 1'b0);
    end
    e = '0; e[EW-1] = 1'b1; e[31:0] = $urandom;
    run_op("msb_top", e, 1, 1'b0);
    run_op("all_ones", '1, 1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
